// File: rtl/alu_pkg.sv
// Shared types for the ALU and the request arbiter that fronts it.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SLL = 4'd5,
    SRL = 4'd6,
    SRA = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Carry on SUB is the unsigned borrow (op1 < op2).
// Ops with bit 3 set are illegal: err=1, result and flags forced to zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]     op1,
  input  logic [XLEN-1:0]     op2,
  input  logic [ALU_OP_W-1:0] op,
  output logic [XLEN-1:0]     result,
  output alu_flags_t          flags,
  output logic                err
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic [SH_W-1:0] shamt;

  assign sum   = {1'b0, op1} + {1'b0, op2};
  assign diff  = {1'b0, op1} - {1'b0, op2};
  assign shamt = op2[SH_W-1:0];

  always_comb begin
    result = '0;
    flags  = '0;
    err    = 1'b0;
    if (op[ALU_OP_W-1]) begin
      err = 1'b1;
    end else begin
      unique case (alu_op_e'(op))
        ADD: begin
          result         = sum[XLEN-1:0];
          flags.carry    = sum[XLEN];
          flags.overflow = (op1[XLEN-1] == op2[XLEN-1]) && (sum[XLEN-1] != op1[XLEN-1]);
        end
        SUB: begin
          result         = diff[XLEN-1:0];
          flags.carry    = diff[XLEN];
          flags.overflow = (op1[XLEN-1] != op2[XLEN-1]) && (diff[XLEN-1] != op1[XLEN-1]);
        end
        AND:     result = op1 & op2;
        OR:      result = op1 | op2;
        XOR:     result = op1 ^ op2;
        SLL:     result = op1 << shamt;
        SRL:     result = op1 >> shamt;
        SRA:     result = $unsigned($signed(op1) >>> shamt);
        default: err = 1'b1;
      endcase
      flags.negative = result[XLEN-1];
      flags.zero     = (result == '0);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters via an IDLE/EXEC/RESP FSM.
// Optional counters stat_ops/stat_stall/stat_err exist when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*XLEN-1:0]      req_op1,
  input  logic [NUM_REQ*XLEN-1:0]      req_op2,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  req_alu_op,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [XLEN-1:0]              rsp_result,
  output logic [3:0]                   rsp_flags,
`ifdef ALU_ARB_STATS_EN
  output logic [31:0]                  stat_ops,
  output logic [31:0]                  stat_stall,
  output logic [15:0]                  stat_err,
`endif
  output logic                         rsp_err
);

  arb_state_e          state, state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [XLEN-1:0]     exe_op1, exe_op2;
  logic [ALU_OP_W-1:0] exe_op;
  logic [ID_W-1:0]     exe_id;

  logic                arb_en;
  logic                accept;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [XLEN-1:0]     alu_result;
  alu_flags_t          alu_flags;
  logic                alu_err;

  // A new grant is possible from IDLE, or from RESP in the cycle the response drains.
  assign arb_en    = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op1    (exe_op1),
    .op2    (exe_op2),
    .op     (exe_op),
    .result (alu_result),
    .flags  (alu_flags),
    .err    (alu_err)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      exe_op1    <= '0;
      exe_op2    <= '0;
      exe_op     <= '0;
      exe_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        exe_op1 <= req_op1[grant_idx*XLEN +: XLEN];
        exe_op2 <= req_op2[grant_idx*XLEN +: XLEN];
        exe_op  <= req_alu_op[grant_idx*ALU_OP_W +: ALU_OP_W];
        exe_id  <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= exe_id;
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_err    <= alu_err;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
      stat_err   <= '0;
    end else begin
      if (rsp_valid && rsp_ready) stat_ops <= stat_ops + 32'd1;
      if (rsp_valid && !rsp_ready) stat_stall <= stat_stall + 32'd1;
      if (rsp_valid && rsp_ready && rsp_err) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: vector table plus scoreboard queues for a 2- and a 3-requester arbiter.
module tb_alu_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        err;
  } rsp_t;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 2-requester instance
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_op1 = '0, req_op2 = '0;
  logic [7:0]  req_alu_op = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_ops, stat_stall;
  logic [15:0] stat_err;
`endif

  // 3-requester instance
  logic [2:0]  v3 = '0;
  logic [2:0]  r3;
  logic [95:0] a3 = '0, b3 = '0;
  logic [11:0] op3 = '0;
  logic        rv3, err3;
  logic [1:0]  rid3;
  logic [31:0] res3;
  logic [3:0]  fl3;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] so3, ss3;
  logic [15:0] se3;
`endif

  rsp_t q2[$];
  rsp_t q3[$];

  alu_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_alu_op (req_alu_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
`ifdef ALU_ARB_STATS_EN
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall),
    .stat_err   (stat_err),
`endif
    .rsp_err    (rsp_err)
  );

  alu_arbiter #(.NUM_REQ(3), .XLEN(32)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (v3),
    .req_ready  (r3),
    .req_op1    (a3),
    .req_op2    (b3),
    .req_alu_op (op3),
    .rsp_valid  (rv3),
    .rsp_ready  (1'b1),
    .rsp_id     (rid3),
    .rsp_result (res3),
    .rsp_flags  (fl3),
`ifdef ALU_ARB_STATS_EN
    .stat_ops   (so3),
    .stat_stall (ss3),
    .stat_err   (se3),
`endif
    .rsp_err    (err3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic rsp_t mk(input int id, input logic [31:0] res, input logic [3:0] fl,
                              input logic err);
    rsp_t r;
    r.id  = 2'(id);
    r.res = res;
    r.fl  = fl;
    r.err = err;
    return r;
  endfunction

  // Scoreboards: pop and compare on every response handshake.
  always @(negedge clk) begin : mon2
    rsp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q2.size() == 0) begin
        check("unexpected_rsp2", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = q2.pop_front();
        check("rsp2_id", 32'(rsp_id), 32'(e.id));
        check("rsp2_result", rsp_result, e.res);
        check("rsp2_flags", 32'(rsp_flags), 32'(e.fl));
        check("rsp2_err", 32'(rsp_err), 32'(e.err));
      end
    end
    if (!rst) begin
      check("ready_subset_valid", 32'(req_ready & ~req_valid), 32'd0);
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("ready3_subset_valid", 32'(r3 & ~v3), 32'd0);
    end
  end

  always @(negedge clk) begin : mon3
    rsp_t e;
    if (!rst && rv3) begin
      if (q3.size() == 0) begin
        check("unexpected_rsp3", {31'd0, rv3}, 32'd0);
      end else begin
        e = q3.pop_front();
        check("rsp3_id", 32'(rid3), 32'(e.id));
        check("rsp3_result", res3, e.res);
        check("rsp3_flags", 32'(fl3), 32'(e.fl));
        check("rsp3_err", 32'(err3), 32'(e.err));
      end
    end
  end

  task automatic wait_accept(input int id);
    bit ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d saw no ready, required ready within 30 cycles",
               id);
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drive(input int id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_op1[id*32 +: 32]  = a;
    req_op2[id*32 +: 32]  = b;
    req_alu_op[id*4 +: 4] = op;
    req_valid[id]         = 1'b1;
  endtask

  task automatic send(input vec_t v);
    @(posedge clk);
    #1;
    drive(v.id, v.op, v.a, v.b);
    q2.push_back(mk(v.id, v.res, v.fl, v.err));
    wait_accept(v.id);
    @(negedge clk);
    check("exec_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rsp_latency", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("rsp_drop_idle", 32'(rsp_valid), 32'd0);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20 && (q2.size() != 0 || q3.size() != 0); c++) @(negedge clk);
    check(name, 32'(q2.size() + q3.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin : main
    logic [1:0] expg[4];
    logic [2:0] exp3[2];
    int k, last, cyc;

    vecs[0]  = '{0, 4'd0, 32'h1,        32'h2,  32'h3,        4'b0000, 1'b0};
    vecs[1]  = '{1, 4'd1, 32'h5,        32'h2,  32'h3,        4'b0000, 1'b0};
    vecs[2]  = '{0, 4'd4, 32'hF,        32'hA,  32'h5,        4'b0000, 1'b0};
    vecs[3]  = '{1, 4'd7, 32'h80000000, 32'h2,  32'hE0000000, 4'b0010, 1'b0};
    vecs[4]  = '{0, 4'd0, 32'hFFFFFFFF, 32'h1,  32'h0,        4'b1001, 1'b0};
    vecs[5]  = '{1, 4'd0, 32'h7FFFFFFF, 32'h1,  32'h80000000, 4'b0110, 1'b0};
    vecs[6]  = '{0, 4'd1, 32'h0,        32'h1,  32'hFFFFFFFF, 4'b1010, 1'b0};
    vecs[7]  = '{1, 4'd2, 32'hF,        32'hA,  32'hA,        4'b0000, 1'b0};
    vecs[8]  = '{0, 4'd3, 32'hF0,       32'h0F, 32'hFF,       4'b0000, 1'b0};
    vecs[9]  = '{1, 4'd5, 32'h1,        32'd31, 32'h80000000, 4'b0010, 1'b0};
    vecs[10] = '{0, 4'd6, 32'h80000000, 32'd31, 32'h1,        4'b0000, 1'b0};
    vecs[11] = '{1, 4'hA, 32'hFFFFFFFF, 32'h1,  32'h0,        4'b0000, 1'b1};
    vecs[12] = '{0, 4'd1, 32'h7,        32'h7,  32'h0,        4'b0001, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);

    foreach (vecs[i]) send(vecs[i]);
`ifdef ALU_ARB_STATS_EN
    check("stat_ops_table", stat_ops, 32'd13);
    check("stat_err_table", 32'(stat_err), 32'd1);
    check("stat_stall_table", stat_stall, 32'd0);
`endif

    // Contention: both held valid, grants alternate on 2-cycle slots.
    pulse_reset();
    expg = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 2; i++) begin
      q2.push_back(mk(0, 32'h3, 4'b0000, 1'b0));
      q2.push_back(mk(1, 32'h5, 4'b0000, 1'b0));
    end
    drive(0, 4'd1, 32'h5, 32'h2);
    drive(1, 4'd4, 32'hF, 32'hA);
    k = 0;
    last = 0;
    for (cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        check("contention_grant", 32'(req_ready), 32'(expg[k]));
        if (k > 0) check("contention_gap", cyc - last, 32'd2);
        last = cyc;
        k++;
      end
    end
    check("contention_grants", k, 32'd4);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("contention_drain");

    // Backpressure: SRA result held 5 cycles, req0 waits, then back-to-back grant.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    drive(1, 4'd7, 32'h80000000, 32'h2);
    q2.push_back(mk(1, 32'hE0000000, 4'b0010, 1'b0));
    wait_accept(1);
    drive(0, 4'd0, 32'h1, 32'h1);
    q2.push_back(mk(0, 32'h2, 4'b0000, 1'b0));
    @(negedge clk);
    check("bp_exec_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_result_held", rsp_result, 32'hE0000000);
      check("bp_negative_held", 32'(rsp_flags[1]), 32'd1);
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_accept(0);
    drain("bp_drain");
`ifdef ALU_ARB_STATS_EN
    check("stat_stall_bp", stat_stall, 32'd5);
`endif

    // Reset in the EXEC cycle drops the op; next req1-only op returns id 1.
    @(posedge clk);
    #1;
    drive(0, 4'd2, 32'hF, 32'hA);
    wait_accept(0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_exec_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("rstmid_result_cleared", rsp_result, 32'd0);
    send('{1, 4'd0, 32'h2, 32'h3, 32'h5, 4'b0000, 1'b0});

    // NUM_REQ=3: only req2, then pointer wraps so req0 beats req2.
    @(posedge clk);
    #1;
    a3[64 +: 32] = 32'h7;
    b3[64 +: 32] = 32'h7;
    op3[8 +: 4]  = 4'd1;
    v3[2]        = 1'b1;
    q3.push_back(mk(2, 32'h0, 4'b0001, 1'b0));
    k = 0;
    for (cyc = 0; cyc < 30 && k == 0; cyc++) begin
      @(negedge clk);
      if (|(v3 & r3)) begin
        check("wrap_single_grant", 32'(r3), 32'h4);
        k++;
      end
    end
    check("wrap_single_accepted", k, 32'd1);
    @(posedge clk);
    #1;
    v3[2] = 1'b0;
    drain("wrap_single_drain");

    @(posedge clk);
    #1;
    a3[0 +: 32] = 32'h1;
    b3[0 +: 32] = 32'h1;
    op3[0 +: 4] = 4'd0;
    v3          = 3'b101;
    q3.push_back(mk(0, 32'h2, 4'b0000, 1'b0));
    q3.push_back(mk(2, 32'h0, 4'b0001, 1'b0));
    exp3 = '{3'b001, 3'b100};
    k = 0;
    for (cyc = 0; cyc < 40 && k < 2; cyc++) begin
      @(negedge clk);
      if (|(v3 & r3)) begin
        check("wrap_pair_grant", 32'(r3), 32'(exp3[k]));
        k++;
        @(posedge clk);
        #1;
        v3 = v3 & ~r3;
      end
    end
    check("wrap_pair_accepted", k, 32'd2);
    v3 = '0;
    drain("wrap_pair_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
